data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Handshaked, multi-cycle responder side of the CPU's data-memory interface.
- Accepts one load or store request at a time from the CPU load/store path, using valid/ready.
- Holds word-organised little-endian storage and performs byte, half and word lane handling with optional sign extension.
- Returns a response after a programmable latency; it replaces the zero-latency data memory once the pipeline gains stall support.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit storage words (power of two)
LATENCY, 2, cycles from the request-accept edge to the first cycle resp_valid_o is high (minimum 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request present
req_ready_o  out  1  responder can accept a request this cycle
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_width_i  in  2  00 byte, 01 half, 10 word, 11 reserved
req_write_i  in  1  1 = store, 0 = load
req_sign_extend_i  in  1  loads only: sign-extend (1) or zero-extend (0)
resp_valid_o  out  1  response present
resp_ready_i  in  1  CPU consumes the response
resp_rdata_o  out  32  load result, right-aligned and extended; 0 for stores and errors
resp_err_o  out  1  request faulted

Behaviour:
- One clock and one reset: clk_i, with synchronous active-high rst_i.
- States are IDLE, WAIT and RESP. The state resets to IDLE.
- During reset: resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, req_ready_o=0.
- Storage contents are not reset.
- req_ready_o = !rst_i & (state==IDLE | (state==RESP & resp_ready_i)). This is combinational and allows back-to-back requests with no dead cycle.
- Accept occurs when req_valid_i & req_ready_o at a rising edge.
- All fault checks, store commit and load-data capture happen at the accept edge. Request inputs are don't-care after acceptance.
- Fault conditions:
  - width 11
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - addr[31:2] >= DEPTH_WORDS
- On a fault: no storage write, and the response carries err=1 with rdata=0.
- Store: byte enables are derived from width and addr[1:0]. Data is replicated into the selected lanes. Unselected bytes are unchanged.
- Load: select the byte or half indicated by addr[1:0], then extend per req_sign_extend_i. Word loads ignore req_sign_extend_i.
- Transitions after accept:
  - LATENCY=1: go directly to RESP.
  - LATENCY>1: go to WAIT and load the down-counter with LATENCY-2. WAIT decrements each cycle and moves to RESP when the counter reaches 0.
- The counter width is clog2(LATENCY) bits, minimum 1.
- In RESP, resp_valid_o=1 and rdata/err are held stable until resp_ready_i.
- On a RESP cycle with resp_ready_i:
  - with a new accept: go to WAIT or RESP per the LATENCY rule;
  - otherwise: go to IDLE with resp_valid_o=0 and rdata/err cleared to 0.
- Outputs change only at clock edges, except req_ready_o.
- Reset mid-operation (WAIT or RESP): return to IDLE immediately and drop the response. A store accepted before the reset remains committed.
- Read-after-write: a load accepted on the cycle after a store to the same word returns the new data.

Decomposition:
- Shared package dmem_pkg holds:
  - width encodings (DMEM_W_BYTE=2'b00, DMEM_W_HALF=2'b01, DMEM_W_WORD=2'b10);
  - the state enum (IDLE, WAIT, RESP).
- The CPU's control decoder uses the same width constants.
- One sub-module, dmem_lane_align, is purely combinational. It takes width, addr[1:0], wdata and sign_extend in, plus the raw read word. It produces:
  - the 4-bit byte enable and aligned write word;
  - the extended load result;
  - the misalignment/reserved-width fault.

Test Plan:
- LATENCY=2: store word 0xDEADBEEF at 0x10 -> resp_valid_o high exactly 2 cycles after accept, err=0, rdata=0. Then load word at 0x10 -> rdata=0xDEADBEEF.
- Store byte 0x80 at 0x13 over 0x00000000, then load byte signed at 0x13 -> 0xFFFFFF80. Unsigned -> 0x00000080. Load word at 0x10 -> 0x80000000.
- Half load at 0x11, word store at 0x12, width 11 at 0x0, address 4*DEPTH_WORDS -> each gives err=1, rdata=0; a later word load shows storage unchanged.
- Back-to-back: hold resp_ready_i=0 for 3 cycles in RESP -> rdata/err stable and req_ready_o=0. Assert resp_ready_i with req_valid_i -> new request accepted the same cycle, with no IDLE cycle.
- Assert rst_i for one cycle during WAIT after a word store of 0x12345678 at 0x20 -> resp_valid_o never rises, req_ready_o=0 that cycle, state IDLE after. A later load at 0x20 -> 0x12345678.
- LATENCY=1 build: load accepted at edge N -> resp_valid_o high after edge N. With resp_ready_i tied high and req_valid_i held, one request accepted every cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder and the CPU control
// decoder: access-width encodings, the responder state type and a helper
// that sizes the latency down-counter.
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Access width encodings (req_width_i); 2'b11 is reserved and faults.
  localparam logic [1:0] DMEM_W_BYTE = 2'b00;
  localparam logic [1:0] DMEM_W_HALF = 2'b01;
  localparam logic [1:0] DMEM_W_WORD = 2'b10;

  // Responder states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  // Down-counter width for a given latency: clog2(latency), at least 1 bit.
  function automatic int dmem_cnt_width(input int latency);
    if (latency <= 2) begin
      return 1;
    end
    return $clog2(latency);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane logic for a 32-bit little-endian word.
//
// Ports:
//   width_i       in   2   access width (DMEM_W_*)
//   addr_lo_i     in   2   byte offset within the word (addr[1:0])
//   wdata_i       in  32   store data, right-aligned
//   sign_extend_i in   1   sign-extend byte/half loads
//   rdata_raw_i   in  32   raw storage word being read
//   be_o          out  4   byte enables for a store
//   wdata_o       out 32   store data replicated into every candidate lane
//   rdata_o       out 32   selected, right-aligned and extended load data
//   fault_o       out  1   misaligned access or reserved width
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic        sign_extend_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction from the raw word.
  always_comb begin
    byte_sel = rdata_raw_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_raw_i[7:0];
      2'd1:    byte_sel = rdata_raw_i[15:8];
      2'd2:    byte_sel = rdata_raw_i[23:16];
      default: byte_sel = rdata_raw_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];
  end

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_raw_i;
    fault_o = 1'b0;
    case (width_i)
      DMEM_W_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        // Replicating the byte means the enables alone pick the lane.
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = sign_extend_i ? {{24{byte_sel[7]}}, byte_sel}
                                : {24'h000000, byte_sel};
      end
      DMEM_W_HALF: begin
        fault_o = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = sign_extend_i ? {{16{half_sel[15]}}, half_sel}
                                : {16'h0000, half_sel};
      end
      DMEM_W_WORD: begin
        fault_o = (addr_lo_i != 2'b00);
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_raw_i;
      end
      default: begin
        fault_o = 1'b1;
        be_o    = 4'b0000;
        wdata_o = '0;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Handshaked, multi-cycle data-memory responder. Accepts one load/store at a
// time, commits stores / captures load data on the accept edge, and presents
// the response LATENCY cycles later until the CPU consumes it.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit storage words (power of two)
//   LATENCY      cycles from accept edge to first resp_valid_o cycle (>= 1)
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake (ready is combinational)
//   req_addr_i                byte address
//   req_wdata_i               store data, right-aligned
//   req_width_i               DMEM_W_BYTE/HALF/WORD, 2'b11 reserved
//   req_write_i               1 = store, 0 = load
//   req_sign_extend_i         sign-extend byte/half loads
//   resp_valid_o/resp_ready_i response handshake
//   resp_rdata_o              load result (0 for stores and faults)
//   resp_err_o                request faulted
// -----------------------------------------------------------------------------
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_width_i,
  input  logic        req_write_i,
  input  logic        req_sign_extend_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int AW       = $clog2(DEPTH_WORDS);
  localparam int CW       = dmem_cnt_width(LATENCY);
  localparam int CNT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;

  dmem_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           accept;
  logic [AW-1:0]  word_idx;
  logic           range_fault;
  logic           lane_fault;
  logic           fault;
  logic [31:0]    raw_word;
  logic [3:0]     be;
  logic [31:0]    wdata_aligned;
  logic [31:0]    load_data;

  assign req_ready_o = !rst_i &&
                       ((state_q == IDLE) || ((state_q == RESP) && resp_ready_i));
  assign accept      = req_valid_i && req_ready_o;

  assign word_idx    = req_addr_i[AW+1:2];
  assign range_fault = ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS));
  assign fault       = range_fault || lane_fault;

  // Read is taken from the current array contents so that a load accepted
  // right after a store to the same word sees the committed data.
  assign raw_word    = mem_q[word_idx];

  dmem_lane_align u_lane_align (
    .width_i       (req_width_i),
    .addr_lo_i     (req_addr_i[1:0]),
    .wdata_i       (req_wdata_i),
    .sign_extend_i (req_sign_extend_i),
    .rdata_raw_i   (raw_word),
    .be_o          (be),
    .wdata_o       (wdata_aligned),
    .rdata_o       (load_data),
    .fault_o       (lane_fault)
  );

  // Storage: byte-lane writes on accept, never reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_write_i && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_aligned[8*b +: 8];
        end
      end
    end
  end

  // Next-state and response-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new accept (from IDLE, or from RESP as the old response is consumed)
    // overrides the return to IDLE so back-to-back requests lose no cycle.
    if (accept) begin
      state_d = (LATENCY == 1) ? RESP : WAIT;
      cnt_d   = CW'(CNT_INIT);
      err_d   = fault;
      rdata_d = (fault || req_write_i) ? 32'h0 : load_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed, table-driven bench for data_mem_responder. One instance is built
// with LATENCY=2 for the main vectors and corner sequences, a second with
// LATENCY=1 for the single-cycle streaming case.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst;

  // LATENCY=2 instance signals
  logic        req_valid, req_ready, req_write, req_sx, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_width;

  // LATENCY=1 instance signals
  logic        req_valid1, req_ready1, req_write1, req_sx1, resp_valid1, resp_ready1, resp_err1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;
  logic [1:0]  req_width1;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_width_i(req_width),
    .req_write_i(req_write), .req_sign_extend_i(req_sx),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_addr_i(req_addr1), .req_wdata_i(req_wdata1), .req_width_i(req_width1),
    .req_write_i(req_write1), .req_sign_extend_i(req_sx1),
    .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready1),
    .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [1:0]  w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sx;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic wr, input logic [1:0] w, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic sx,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.w = w; v.addr = addr; v.wdata = wdata; v.sx = sx;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request on the LATENCY=2 instance, measure latency, check the
  // response, consume it and check the return to an idle, cleared response.
  task automatic run_req(input vec_t v, input string tag);
    int cyc;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_width  = v.w;
    req_write  = v.wr;
    req_sx     = v.sx;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'd2);
    chk({tag, " rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(resp_err), 32'(v.exp_err));
    $display("txn %s wr=%0d w=%0d addr=%h wdata=%h sx=%0d -> rdata=%h err=%0d lat=%0d",
             tag, v.wr, v.w, v.addr, v.wdata, v.sx, resp_rdata, resp_err, cyc);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " idle valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " idle rdata"}, resp_rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] held;
    logic [7:0]  exp_b [4];
    logic        ever_valid;

    // Hand-computed vectors for the LATENCY=2 instance.
    vecs[0]  = mk(1, DMEM_W_WORD, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0);
    vecs[1]  = mk(0, DMEM_W_WORD, 32'h10,   32'h0,        0, 32'hDEADBEEF, 0);
    vecs[2]  = mk(1, DMEM_W_WORD, 32'h10,   32'h00000000, 0, 32'h0,        0);
    vecs[3]  = mk(1, DMEM_W_BYTE, 32'h13,   32'h12345680, 0, 32'h0,        0);
    vecs[4]  = mk(0, DMEM_W_BYTE, 32'h13,   32'h0,        1, 32'hFFFFFF80, 0);
    vecs[5]  = mk(0, DMEM_W_BYTE, 32'h13,   32'h0,        0, 32'h00000080, 0);
    vecs[6]  = mk(0, DMEM_W_WORD, 32'h10,   32'h0,        0, 32'h80000000, 0);
    vecs[7]  = mk(1, DMEM_W_WORD, 32'h0,    32'hA5A5A5A5, 0, 32'h0,        0);
    vecs[8]  = mk(0, DMEM_W_HALF, 32'h11,   32'h0,        0, 32'h0,        1);
    vecs[9]  = mk(1, DMEM_W_WORD, 32'h12,   32'h11111111, 0, 32'h0,        1);
    vecs[10] = mk(1, 2'b11,       32'h0,    32'h22222222, 0, 32'h0,        1);
    vecs[11] = mk(1, DMEM_W_WORD, 32'h1000, 32'h33333333, 0, 32'h0,        1);
    vecs[12] = mk(0, DMEM_W_WORD, 32'h10,   32'h0,        1, 32'h80000000, 0);
    vecs[13] = mk(0, DMEM_W_WORD, 32'h0,    32'h0,        0, 32'hA5A5A5A5, 0);
    vecs[14] = mk(1, DMEM_W_WORD, 32'h14,   32'h00000000, 0, 32'h0,        0);
    vecs[15] = mk(1, DMEM_W_HALF, 32'h16,   32'hFFFF8001, 0, 32'h0,        0);
    vecs[16] = mk(0, DMEM_W_HALF, 32'h16,   32'h0,        1, 32'hFFFF8001, 0);
    vecs[17] = mk(0, DMEM_W_HALF, 32'h16,   32'h0,        0, 32'h00008001, 0);
    vecs[18] = mk(0, DMEM_W_WORD, 32'h14,   32'h0,        0, 32'h80010000, 0);
    vecs[19] = mk(0, DMEM_W_BYTE, 32'h17,   32'h0,        1, 32'hFFFFFF80, 0);
    vecs[20] = mk(0, DMEM_W_BYTE, 32'h16,   32'h0,        1, 32'h00000001, 0);
    vecs[21] = mk(1, DMEM_W_BYTE, 32'h15,   32'h000000C3, 0, 32'h0,        0);
    vecs[22] = mk(0, DMEM_W_WORD, 32'h14,   32'h0,        0, 32'h8001C300, 0);

    req_valid = 0; req_addr = 0; req_wdata = 0; req_width = 0; req_write = 0;
    req_sx = 0; resp_ready = 0;
    req_valid1 = 0; req_addr1 = 0; req_wdata1 = 0; req_width1 = 0; req_write1 = 0;
    req_sx1 = 0; resp_ready1 = 0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset rdata", resp_rdata, 32'h0);
    chk("reset err", 32'(resp_err), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset resp_valid1", 32'(resp_valid1), 32'd0);
    chk("reset req_ready1", 32'(req_ready1), 32'd0);
    rst = 1'b0;
    #1;
    chk("post reset req_ready", 32'(req_ready), 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back: stall in RESP for 3 cycles, then consume + accept together.
    req_addr = 32'h10; req_width = DMEM_W_WORD; req_write = 1'b0; req_sx = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    // Next request is offered while the first is outstanding.
    req_addr = 32'h0;
    @(posedge clk); #1;
    chk("b2b first valid", 32'(resp_valid), 32'd1);
    held = resp_rdata;
    chk("b2b first rdata", held, 32'h80000000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b stall%0d valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("b2b stall%0d rdata", k), resp_rdata, 32'h80000000);
      chk($sformatf("b2b stall%0d err", k), 32'(resp_err), 32'd0);
      chk($sformatf("b2b stall%0d req_ready", k), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("b2b ready with resp_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    #1;
    // Not IDLE: an IDLE state would raise req_ready.
    chk("b2b no idle req_ready", 32'(req_ready), 32'd0);
    chk("b2b wait valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("b2b second valid", 32'(resp_valid), 32'd1);
    chk("b2b second rdata", resp_rdata, 32'hA5A5A5A5);
    $display("txn b2b second load addr=00000000 -> rdata=%h", resp_rdata);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("b2b done valid", 32'(resp_valid), 32'd0);

    // Reset during WAIT after a word store.
    req_addr = 32'h20; req_wdata = 32'h12345678; req_width = DMEM_W_WORD;
    req_write = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst mid req_ready", 32'(req_ready), 32'd0);
    chk("rst mid valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst after req_ready", 32'(req_ready), 32'd1);
    chk("rst after rdata", resp_rdata, 32'h0);
    ever_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) ever_valid = 1'b1;
    end
    chk("rst no response", 32'(ever_valid), 32'd0);
    $display("txn reset-in-wait store addr=00000020 dropped");
    run_req(mk(0, DMEM_W_WORD, 32'h20, 32'h0, 0, 32'h12345678, 0), "rst_load");

    // LATENCY=1 instance: store then streaming loads, one accept per cycle.
    exp_b[0] = 8'h0D; exp_b[1] = 8'hF0; exp_b[2] = 8'hFE; exp_b[3] = 8'hCA;
    resp_ready1 = 1'b1;
    req_addr1 = 32'h40; req_wdata1 = 32'hCAFEF00D; req_width1 = DMEM_W_WORD;
    req_write1 = 1'b1; req_sx1 = 1'b0; req_valid1 = 1'b1;
    #1;
    chk("l1 store ready", 32'(req_ready1), 32'd1);
    @(posedge clk); #1;
    chk("l1 store valid", 32'(resp_valid1), 32'd1);
    chk("l1 store rdata", resp_rdata1, 32'h0);
    chk("l1 store err", 32'(resp_err1), 32'd0);
    $display("txn l1 store addr=00000040 wdata=cafef00d");
    req_write1 = 1'b0;
    #1;
    chk("l1 load ready", 32'(req_ready1), 32'd1);
    @(posedge clk); #1;
    chk("l1 load valid", 32'(resp_valid1), 32'd1);
    chk("l1 load rdata", resp_rdata1, 32'hCAFEF00D);
    $display("txn l1 load addr=00000040 -> rdata=%h", resp_rdata1);
    req_width1 = DMEM_W_BYTE;
    for (int i = 0; i < 4; i++) begin
      req_addr1 = 32'h40 + 32'(i);
      #1;
      chk($sformatf("l1 stream%0d ready", i), 32'(req_ready1), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("l1 stream%0d valid", i), 32'(resp_valid1), 32'd1);
      chk($sformatf("l1 stream%0d rdata", i), resp_rdata1, {24'h0, exp_b[i]});
      $display("txn l1 byte load addr=%h -> rdata=%h", req_addr1, resp_rdata1);
    end
    req_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("l1 idle valid", 32'(resp_valid1), 32'd0);
    chk("l1 idle rdata", resp_rdata1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
